// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared constants for the 2-digit 7-segment scan driver.
//   SEG_0..SEG_9 : active-low {g,f,e,d,c,b,a} glyphs for BCD digits
//   SEG_DASH     : out-of-range indicator for codes 10..15
//   SEG_OFF      : every segment dark
//   AN_*         : active-low anode patterns (an[0] = ones, an[1] = tens)
//   sel_e        : which digit the scanner is currently driving
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } sel_e;

endpackage

// File: rtl/seg_scan_driver_seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment decoder.
//   digit : 4-bit code; 0..9 map to glyphs, 10..15 show a dash
//   seg_n : {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  // Glyph lookup; anything outside 0..9 is flagged with a dash, never blank.
  always_comb begin
    seg_n = SEG_DASH;
    case (digit)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: latches a tens/ones BCD pair and time-multiplexes it onto
// a 2-digit common-anode 7-segment display.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture strobe for tens/ones
//   tens, ones : BCD digits from split_digits
//   blank_lz   : hide a tens digit of 0
//   blink_en   : blink the whole display (wrong-answer flag)
//   seg        : registered active-low segments {g,f,e,d,c,b,a}
//   an         : registered active-low anodes, an[0] = ones, an[1] = tens
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  sel_e          sel_q, sel_d;
  logic          dead_q, dead_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic          tick_s;
  logic [3:0]    shown_digit_s;
  logic [6:0]    dec_seg_s;
  logic          phase_on_s;
  logic          blanked_s;

  seg7_decode u_decode (
    .digit (shown_digit_s),
    .seg_n (dec_seg_s)
  );

  // Next-state: prescaler, digit select, dead cycle, blink and digit latches.
  always_comb begin
    tick_s      = (presc_q == PRESC_LAST);
    presc_d     = presc_q;
    sel_d       = sel_q;
    dead_d      = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    tens_d      = tens_q;
    ones_d      = ones_q;

    if (tick_s) begin
      presc_d = {PW{1'b0}};
      sel_d   = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
      // One dark cycle while the anode moves keeps the old glyph from ghosting.
      dead_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (!blink_en) begin
      blink_cnt_d = {BW{1'b0}};
      blink_on_d  = 1'b1;
    end else if (tick_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BW{1'b0}};
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end

    if (load) begin
      tens_d = tens;
      ones_d = ones;
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  // Output decision: segments always track the selected digit; anodes blank.
  always_comb begin
    shown_digit_s = (sel_q == SEL_TENS) ? tens_q : ones_q;
    seg_d         = dec_seg_s;
    // Dropping blink_en must restore the display immediately, so the stale
    // phase register is ignored whenever blinking is off.
    phase_on_s    = (!blink_en) || blink_on_q;
    blanked_s     = dead_q || !phase_on_s ||
                    ((sel_q == SEL_TENS) && blank_lz && (tens_q == 4'd0));
    an_d          = AN_OFF;
    if (blanked_s) begin
      an_d = AN_OFF;
    end else if (sel_q == SEL_TENS) begin
      an_d = AN_TENS;
    end else begin
      an_d = AN_ONES;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= {PW{1'b0}};
      sel_q       <= SEL_ONES;
      dead_q      <= 1'b1;
      blink_cnt_q <= {BW{1'b0}};
      blink_on_q  <= 1'b1;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      presc_q     <= presc_d;
      sel_q       <= sel_d;
      dead_q      <= dead_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, BLINK_TICKS=2).
// The reference model tracks the number of edges since reset and the number
// of scan ticks since blinking was enabled, and derives the expected display
// from those counts with plain arithmetic.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BT = 2;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic       blink_en;
  logic [6:0] seg;
  logic [1:0] an;

  int errors;
  int checks;

  // Reference model state.
  int         k;
  int         bt;
  logic [3:0] mt;
  logic [3:0] mo;
  logic [6:0] dec_tab [16];

  seg_scan_driver #(
    .SCAN_DIV    (SD),
    .BLINK_TICKS (BT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .tens     (tens),
    .ones     (ones),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: predict the outputs from the inputs present at the edge,
  // then compare #1 after the edge.
  task automatic cyc();
    logic [6:0] es;
    logic [1:0] ea;
    int         sel;
    bit         dead;
    bit         on;
    @(posedge clk);
    if (rst) begin
      es = 7'h7F;
      ea = 2'b11;
      k  = 0;
      bt = 0;
      mt = 4'd0;
      mo = 4'd0;
    end else begin
      sel  = (k / SD) % 2;
      dead = ((k % SD) == 0);
      on   = !blink_en || (((bt / BT) % 2) == 0);
      es   = dec_tab[(sel == 1) ? mt : mo];
      if (dead || !on || (sel == 1 && blank_lz && mt == 4'd0)) ea = 2'b11;
      else ea = (sel == 1) ? 2'b01 : 2'b10;
      if (blink_en) begin
        if ((k % SD) == SD - 1) bt++;
      end else begin
        bt = 0;
      end
      if (load) begin
        mt = tens;
        mo = ones;
      end
      k++;
    end
    #1;
    checks++;
    assert (seg === es) else begin
      errors++;
      $error("FAIL seg k=%0d: got %h expected %h", k, seg, es);
    end
    checks++;
    assert (an === ea) else begin
      errors++;
      $error("FAIL an k=%0d: got %b expected %b", k, an, ea);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    tens = t;
    ones = o;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    errors   = 0;
    checks   = 0;
    k        = 0;
    bt       = 0;
    mt       = 4'd0;
    mo       = 4'd0;
    rst      = 1'b1;
    load     = 1'b0;
    tens     = 4'd0;
    ones     = 4'd0;
    blank_lz = 1'b0;
    blink_en = 1'b0;

    // Reset held 3 cycles, then free-run.
    run(3);
    rst = 1'b0;
    run(6);

    // Plain digits 1,5.
    do_load(4'd1, 4'd5);
    run(16);

    // Leading-zero blanking on and off.
    blank_lz = 1'b1;
    do_load(4'd0, 4'd3);
    run(16);
    blank_lz = 1'b0;
    run(16);

    // Out-of-range codes show a dash.
    do_load(4'd15, 4'd10);
    run(16);

    // Blink, then drop blink mid-blank.
    do_load(4'd4, 4'd2);
    blink_en = 1'b1;
    run(40);
    for (int i = 0; i < 20 && (((bt / BT) % 2) == 0); i++) cyc();
    blink_en = 1'b0;
    run(12);

    // Held load recaptures every cycle.
    load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tens = 4'(i);
      ones = 4'(9 - i);
      cyc();
    end
    load = 1'b0;
    run(8);

    // Reset in the middle of a tens window.
    do_load(4'd9, 4'd9);
    for (int i = 0; i < 20 && !(((k / SD) % 2) == 1 && (k % SD) == 2); i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(12);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 5) == 0);
      tens = 4'($urandom_range(0, 15));
      ones = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
      cyc();
    end
    rst  = 1'b0;
    load = 1'b0;
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
